vga_sync_rx: RTL and testbench
==============================

Name: vga_sync_rx

Overview:
- Receive-side counterpart of the VGA timing generator: samples active-low HSYNC/VSYNC and 10-bit RGB, one pixel per clock, in the same clock domain as the generator.
- Measures line length, HSYNC pulse width and lines per frame.
- Locks once it has seen enough consecutive frames with the expected timing.
- While locked, emits per-pixel coordinates plus a valid strobe and the gated RGB data. Used as a loopback checker and as a video capture front end.

Parameters:
- H_TOTAL, 798, expected clocks per line (falling HSYNC edge to the next falling HSYNC edge).
- V_TOTAL, 526, expected lines per frame.
- H_ACT_START, 131, value of h_cnt at the first active pixel.
- H_ACT, 640, active pixels per line.
- V_ACT_START, 35, value of v_cnt at the first active line.
- V_ACT, 480, active lines per frame.
- LOCK_FRAMES, 2, number of consecutive good frames required to enter LOCKED (range 1..15).

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  synchronous reset, active-high
- i_h_sync  in  1  horizontal sync, active low
- i_v_sync  in  1  vertical sync, active low
- i_red / i_green / i_blue  in  10 each  pixel data
- o_pix_valid  out  1  high while locked and inside the active region
- o_x  out  10  active-area column, 0..H_ACT-1
- o_y  out  10  active-area row, 0..V_ACT-1
- o_red / o_green / o_blue  out  10 each  pixel data, forced to 0 when o_pix_valid=0
- o_frame_start  out  1  one-cycle pulse, coincident with the o_pix_valid beat where x=0, y=0
- o_locked  out  1  FSM is in LOCKED
- o_err  out  1  one-cycle pulse on loss of lock
- o_line_len  out  10  last measured line length
- o_hsync_width  out  10  last measured HSYNC low width
- o_frame_lines  out  10  last measured lines per frame

Behaviour:
- Reset (synchronous, active-high):
  - All outputs are 0.
  - Sync sample registers and their delayed copies are 1, so no spurious edge is detected.
  - h_cnt=0, v_cnt=0, FSM=SEARCH, good_cnt=0, line_err=0.
  - Reset asserted mid-frame has the same effect, and lock is dropped without an o_err pulse.
- Input stage: one register stage (s_h, s_v, s_rgb). Edge detects compare against the delayed copies:
  - h_fall = s_h_d & ~s_h
  - h_rise = ~s_h_d & s_h
  - v_fall = s_v_d & ~s_v
- h_cnt:
  - On h_fall: h_cnt <= 0 and o_line_len <= h_cnt+1.
  - Otherwise: h_cnt increments, saturating at 1023.
- HSYNC width: on h_rise, o_hsync_width <= h_cnt+1.
- v_cnt:
  - On v_fall: o_frame_lines <= v_cnt + h_fall (the same-cycle HSYNC edge counts), then v_cnt <= 0.
  - On h_fall without v_fall: v_cnt <= v_cnt+1, saturating at 1023.
- Line check: on h_fall while in CHECK or LOCKED, line_err is set if h_cnt+1 != H_TOTAL.
- Timeout: h_cnt == 1023 (no HSYNC) counts as a bad line.
- FSM:
  - SEARCH: on v_fall -> CHECK, good_cnt=0, line_err=0.
  - CHECK: on v_fall the frame is good when (v_cnt+h_fall)==V_TOTAL and line_err==0.
    - Good frame: good_cnt++. If the new count equals LOCK_FRAMES -> LOCKED, otherwise stay.
    - Bad frame: good_cnt=0 and stay in CHECK.
    - line_err is cleared at every v_fall.
  - LOCKED:
    - A bad line (at h_fall) or timeout -> SEARCH with an o_err pulse in the same cycle as the transition.
    - v_fall with a frame count != V_TOTAL -> SEARCH with an o_err pulse.
    - o_locked=1 only in this state.
- Active region (evaluated on the internal counters):
  - H_ACT_START <= h_cnt < H_ACT_START+H_ACT, and
  - V_ACT_START <= v_cnt < V_ACT_START+V_ACT, and
  - state is LOCKED.
- Output register:
  - Inside the active region: o_pix_valid=1, o_x=h_cnt-H_ACT_START, o_y=v_cnt-V_ACT_START, o_rgb=s_rgb.
  - Otherwise: o_pix_valid=0, rgb=0, and o_x/o_y hold their last values.
- Latency: 2 clocks from the pins to the outputs.
- Subtractions are 10-bit and are used only inside the region, so they never wrap.
- Simultaneous h_fall and v_fall (the normal case for the generator) is handled exactly as stated under v_cnt; the test plan covers it.

Test Plan:
- Ideal 798x526 stream (HSYNC low 95 clks, VSYNC low 2 lines, both falling on the same clock), LOCK_FRAMES=2 -> o_line_len=798, o_hsync_width=95, o_frame_lines=526; o_locked rises at the 3rd v_fall; o_err stays 0.
- Locked stream carrying RGB = column index -> exactly 640 o_pix_valid beats per active line and 480 active lines per frame; o_x runs 0..639, o_y 0..479; o_red==o_x; o_frame_start pulses once per frame with x=0, y=0.
- Locked, one line shortened to 797 clocks -> o_err pulses exactly once at that h_fall; o_locked=0 and o_pix_valid=0 from the next cycle; relock happens after 2 further good frames following the next v_fall.
- HSYNC held high for 1100 clocks while locked -> o_err pulse when h_cnt reaches 1023; h_cnt saturates and does not wrap.
- VSYNC falling 2 clocks after HSYNC (non-simultaneous) -> o_frame_lines=526 for a 526-line frame, matching the count of HSYNC falls between VSYNC falls.
- i_rst asserted mid-active-line while locked -> next cycle all outputs are 0 and the FSM is in SEARCH with no o_err pulse; lock is regained after 3 v_falls.

Source files
------------

// File: rtl/vga_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_rx
//  Description : VGA timing receiver. Samples HSYNC/VSYNC/RGB, measures line
//                length, HSYNC width and frame height, locks after a run of
//                good frames, and emits active-area coordinates with gated RGB.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_rx #(
    parameter int H_TOTAL     = 798,
    parameter int V_TOTAL     = 526,
    parameter int H_ACT_START = 131,
    parameter int H_ACT       = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_h_sync,
    input  logic       i_v_sync,
    input  logic [9:0] i_red,
    input  logic [9:0] i_green,
    input  logic [9:0] i_blue,
    output logic       o_pix_valid,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic [9:0] o_red,
    output logic [9:0] o_green,
    output logic [9:0] o_blue,
    output logic       o_frame_start,
    output logic       o_locked,
    output logic       o_err,
    output logic [9:0] o_line_len,
    output logic [9:0] o_hsync_width,
    output logic [9:0] o_frame_lines
);

    // 11-bit constants so that count+1 comparisons never wrap
    localparam logic [10:0] c_h_total     = 11'(H_TOTAL);
    localparam logic [10:0] c_v_total     = 11'(V_TOTAL);
    localparam logic [10:0] c_h_act_start = 11'(H_ACT_START);
    localparam logic [10:0] c_h_act_end   = 11'(H_ACT_START + H_ACT);
    localparam logic [10:0] c_v_act_start = 11'(V_ACT_START);
    localparam logic [10:0] c_v_act_end   = 11'(V_ACT_START + V_ACT);
    localparam logic [3:0]  c_lock_frames = 4'(LOCK_FRAMES);
    localparam logic [9:0]  c_cnt_max     = 10'h3FF;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Input stage
    logic        s_h_q, s_v_q, s_h_dly_q, s_v_dly_q;
    logic [29:0] s_rgb_q;

    // Measurement counters
    logic [9:0]  h_cnt_q, v_cnt_q;
    logic [9:0]  line_len_q, hsync_width_q, frame_lines_q;

    // FSM
    state_t      state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic        line_err_q, line_err_d;
    logic        w_err;

    // Output register
    logic        pix_valid_q, frame_start_q;
    logic [9:0]  x_q, y_q;
    logic [29:0] rgb_q;

    logic        w_h_fall, w_h_rise, w_v_fall;
    logic [10:0] w_h_cnt_inc, w_frame_cnt;
    logic [9:0]  w_h_len, w_frame_len;
    logic        w_timeout, w_bad_line, w_frame_ok;
    logic        w_in_h, w_in_v, w_active;

    assign w_h_fall = s_h_dly_q & ~s_h_q;
    assign w_h_rise = ~s_h_dly_q & s_h_q;
    assign w_v_fall = s_v_dly_q & ~s_v_q;

    // Measured values saturate at 1023 rather than wrapping after a timeout
    assign w_h_cnt_inc = {1'b0, h_cnt_q} + 11'd1;
    assign w_h_len     = w_h_cnt_inc[10] ? c_cnt_max : w_h_cnt_inc[9:0];
    // A same-cycle HSYNC edge closes the last line of the frame
    assign w_frame_cnt = {1'b0, v_cnt_q} + {10'd0, w_h_fall};
    assign w_frame_len = w_frame_cnt[10] ? c_cnt_max : w_frame_cnt[9:0];

    assign w_timeout  = (h_cnt_q == c_cnt_max);
    assign w_bad_line = (w_h_fall && (w_h_cnt_inc != c_h_total)) || w_timeout;
    assign w_frame_ok = (w_frame_cnt == c_v_total);

    assign w_in_h   = ({1'b0, h_cnt_q} >= c_h_act_start) && ({1'b0, h_cnt_q} < c_h_act_end);
    assign w_in_v   = ({1'b0, v_cnt_q} >= c_v_act_start) && ({1'b0, v_cnt_q} < c_v_act_end);
    assign w_active = w_in_h && w_in_v && (state_q == ST_LOCKED);

    // Register the pins once; keep a delayed copy of the syncs for edge detection
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_h_q     <= 1'b1;
            s_v_q     <= 1'b1;
            s_h_dly_q <= 1'b1;
            s_v_dly_q <= 1'b1;
            s_rgb_q   <= '0;
        end else begin
            s_h_q     <= i_h_sync;
            s_v_q     <= i_v_sync;
            s_h_dly_q <= s_h_q;
            s_v_dly_q <= s_v_q;
            s_rgb_q   <= {i_red, i_green, i_blue};
        end
    end

    // Horizontal/vertical position counters and timing measurements
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            line_len_q    <= '0;
            hsync_width_q <= '0;
            frame_lines_q <= '0;
        end else begin
            if (w_h_fall) begin
                h_cnt_q    <= '0;
                line_len_q <= w_h_len;
            end else if (!w_timeout) begin
                h_cnt_q <= h_cnt_q + 10'd1;
            end
            if (w_h_rise) begin
                hsync_width_q <= w_h_len;
            end
            if (w_v_fall) begin
                frame_lines_q <= w_frame_len;
                v_cnt_q       <= '0;
            end else if (w_h_fall && (v_cnt_q != c_cnt_max)) begin
                v_cnt_q <= v_cnt_q + 10'd1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_SEARCH;
            good_cnt_q <= '0;
            line_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            line_err_q <= line_err_d;
        end
    end

    // FSM next state: search for VSYNC, qualify frames, then supervise the lock
    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        line_err_d = line_err_q;
        w_err      = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (w_v_fall) begin
                    state_d    = ST_CHECK;
                    good_cnt_d = '0;
                    line_err_d = 1'b0;
                end
            end
            ST_CHECK: begin
                if (w_v_fall) begin
                    line_err_d = 1'b0;
                    // The line closed by a coincident HSYNC edge belongs to this frame
                    if (w_frame_ok && !line_err_q && !w_bad_line) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if ((good_cnt_q + 4'd1) == c_lock_frames) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (w_bad_line) begin
                    line_err_d = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_bad_line || (w_v_fall && !w_frame_ok)) begin
                    state_d    = ST_SEARCH;
                    good_cnt_d = '0;
                    w_err      = 1'b1;
                end
            end
            default: begin
                state_d    = ST_SEARCH;
                good_cnt_d = '0;
                line_err_d = 1'b0;
            end
        endcase
    end

    // Output register: coordinates and gated pixel data for the active region
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            rgb_q         <= '0;
        end else if (w_active) begin
            pix_valid_q   <= 1'b1;
            frame_start_q <= (h_cnt_q == c_h_act_start[9:0]) && (v_cnt_q == c_v_act_start[9:0]);
            x_q           <= h_cnt_q - c_h_act_start[9:0];
            y_q           <= v_cnt_q - c_v_act_start[9:0];
            rgb_q         <= s_rgb_q;
        end else begin
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end
    end

    assign o_pix_valid   = pix_valid_q;
    assign o_frame_start = frame_start_q;
    assign o_x           = x_q;
    assign o_y           = y_q;
    assign o_red         = rgb_q[29:20];
    assign o_green       = rgb_q[19:10];
    assign o_blue        = rgb_q[9:0];
    assign o_locked      = (state_q == ST_LOCKED);
    // Reset drops lock silently
    assign o_err         = w_err & ~i_rst;
    assign o_line_len    = line_len_q;
    assign o_hsync_width = hsync_width_q;
    assign o_frame_lines = frame_lines_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_rx
//  Description : Directed self-checking bench for vga_sync_rx on a scaled
//                40x12 raster (active 20x6 at h=8, v=3, HSYNC 5 clocks).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_rx;

    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HAS = 8;
    localparam int HA  = 20;
    localparam int VAS = 3;
    localparam int VA  = 6;
    localparam int HSW = 5;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_h_sync = 1'b1, i_v_sync = 1'b1;
    logic [9:0] i_red = '0, i_green = '0, i_blue = '0;
    logic       o_pix_valid, o_frame_start, o_locked, o_err;
    logic [9:0] o_x, o_y, o_red, o_green, o_blue;
    logic [9:0] o_line_len, o_hsync_width, o_frame_lines;

    int errors = 0;
    int checks = 0;

    vga_sync_rx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACT(HA),
        .V_ACT_START(VAS), .V_ACT(VA), .LOCK_FRAMES(2)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_h_sync(i_h_sync), .i_v_sync(i_v_sync),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .o_pix_valid(o_pix_valid), .o_x(o_x), .o_y(o_y),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
        .o_frame_start(o_frame_start), .o_locked(o_locked), .o_err(o_err),
        .o_line_len(o_line_len), .o_hsync_width(o_hsync_width), .o_frame_lines(o_frame_lines)
    );

    always #5 clk = ~clk;

    // Monitor: running event counters read as deltas by the test tasks
    int   beats = 0, fs_cnt = 0, err_cnt = 0, mon_bad = 0;
    int   good_lines = 0, bad_runs = 0, run_len = 0, post_err_bad = 0;
    logic prev_err = 1'b0;

    always @(negedge clk) begin
        if (o_err) err_cnt++;
        if (prev_err && (o_locked || o_pix_valid)) post_err_bad++;
        prev_err = o_err;
        if (o_pix_valid) begin
            beats++;
            run_len++;
            if (o_red !== o_x || o_green !== o_y || o_blue !== 10'h155) mon_bad++;
        end else begin
            if (run_len != 0) begin
                if (run_len == HA) good_lines++;
                else bad_runs++;
            end
            run_len = 0;
            if ({o_red, o_green, o_blue} !== 30'd0) mon_bad++;
        end
        if (o_frame_start) begin
            fs_cnt++;
            if (!o_pix_valid || o_x !== 10'd0 || o_y !== 10'd0) mon_bad++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic h, input logic v, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        i_h_sync = h;
        i_v_sync = v;
        i_red    = r;
        i_green  = g;
        i_blue   = b;
        @(posedge clk);
        #1;
    endtask

    // One frame of the scaled raster. Active pixel at column g of line l carries
    // red=column index, green=row index; blanking carries all-ones garbage.
    task automatic send_frame(input int vdel, input int short_line, input int stop_at);
        int p;
        p = 0;
        for (int l = 0; l < VT; l++) begin
            int len;
            len = (l == short_line) ? HT - 1 : HT;
            for (int g = 0; g < len; g++) begin
                logic h, v;
                logic [9:0] r, gr, b;
                if (stop_at >= 0 && p == stop_at) return;
                h = (g < HSW) ? 1'b0 : 1'b1;
                v = (p >= vdel && p < vdel + 2 * HT) ? 1'b0 : 1'b1;
                if (l >= VAS && l < VAS + VA && g >= HAS + 1 && g < HAS + 1 + HA) begin
                    r  = 10'(g - HAS - 1);
                    gr = 10'(l - VAS);
                    b  = 10'h155;
                end else begin
                    r  = 10'h3FF;
                    gr = 10'h3FF;
                    b  = 10'h3FF;
                end
                cyc(h, v, r, gr, b);
                p++;
            end
        end
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        repeat (3) cyc(1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        checks++; if (o_pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid: got %b want 0", o_pix_valid); end
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", o_locked); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", o_err); end
        checks++; if ({o_red, o_green, o_blue} !== 30'd0) begin errors++; $display("FAIL reset_rgb: got %h want 0", {o_red, o_green, o_blue}); end
        checks++; if ({o_line_len, o_hsync_width, o_frame_lines} !== 30'd0) begin errors++; $display("FAIL reset_meas: got %h want 0", {o_line_len, o_hsync_width, o_frame_lines}); end
        i_rst = 1'b0;
        cyc(1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
    endtask

    task automatic test_lock;
        int e0;
        e0 = err_cnt;
        send_frame(0, -1, -1);
        send_frame(0, -1, -1);
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", o_locked); end
        checks++; if (o_line_len !== 10'd40) begin errors++; $display("FAIL line_len: got %0d want 40", o_line_len); end
        checks++; if (o_hsync_width !== 10'd5) begin errors++; $display("FAIL hsync_width: got %0d want 5", o_hsync_width); end
        checks++; if (o_frame_lines !== 10'd12) begin errors++; $display("FAIL frame_lines: got %0d want 12", o_frame_lines); end
        send_frame(0, -1, -1);
        checks++; if (o_locked !== 1'b1) begin errors++; $display("FAIL lock_third_vfall: got %b want 1", o_locked); end
        checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL lock_no_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_back_to_back;
        int b0, l0, r0, f0, m0, e0;
        b0 = beats; l0 = good_lines; r0 = bad_runs; f0 = fs_cnt; m0 = mon_bad; e0 = err_cnt;
        send_frame(0, -1, -1);
        send_frame(0, -1, -1);
        checks++; if (beats - b0 !== 2 * HA * VA) begin errors++; $display("FAIL pix_beats: got %0d want %0d", beats - b0, 2 * HA * VA); end
        checks++; if (good_lines - l0 !== 2 * VA) begin errors++; $display("FAIL full_lines: got %0d want %0d", good_lines - l0, 2 * VA); end
        checks++; if (bad_runs - r0 !== 0) begin errors++; $display("FAIL partial_lines: got %0d want 0", bad_runs - r0); end
        checks++; if (fs_cnt - f0 !== 2) begin errors++; $display("FAIL frame_start_cnt: got %0d want 2", fs_cnt - f0); end
        checks++; if (mon_bad - m0 !== 0) begin errors++; $display("FAIL pix_data: got %0d bad beats want 0", mon_bad - m0); end
        checks++; if (err_cnt - e0 !== 0 || o_locked !== 1'b1) begin errors++; $display("FAIL stay_locked: got err=%0d locked=%b want 0/1", err_cnt - e0, o_locked); end
    endtask

    task automatic test_short_line;
        int e0, b0, p0;
        e0 = err_cnt; b0 = beats; p0 = post_err_bad;
        send_frame(0, 5, -1);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL short_err_pulses: got %0d want 1", err_cnt - e0); end
        checks++; if (post_err_bad - p0 !== 0) begin errors++; $display("FAIL short_after_err: got %0d bad cycles want 0", post_err_bad - p0); end
        checks++; if (beats - b0 !== 3 * HA) begin errors++; $display("FAIL short_beats: got %0d want %0d", beats - b0, 3 * HA); end
        send_frame(0, -1, -1);
        send_frame(0, -1, -1);
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL short_relock_early: got %b want 0", o_locked); end
        send_frame(0, -1, -1);
        checks++; if (o_locked !== 1'b1 || err_cnt - e0 !== 1) begin errors++; $display("FAIL short_relock: got locked=%b err=%0d want 1/1", o_locked, err_cnt - e0); end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        repeat (1100) cyc(1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0); end
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL timeout_unlock: got %b want 0", o_locked); end
        repeat (HSW) cyc(1'b0, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        repeat (3) cyc(1'b1, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF);
        checks++; if (o_line_len !== 10'd1023) begin errors++; $display("FAIL timeout_saturate: got %0d want 1023", o_line_len); end
        checks++; if (o_hsync_width !== 10'd5) begin errors++; $display("FAIL timeout_hsw: got %0d want 5", o_hsync_width); end
    endtask

    task automatic test_vsync_offset;
        send_frame(2, -1, -1);
        send_frame(2, -1, -1);
        checks++; if (o_frame_lines !== 10'd12) begin errors++; $display("FAIL voff_frame_lines: got %0d want 12", o_frame_lines); end
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL voff_lock_early: got %b want 0", o_locked); end
        send_frame(2, -1, -1);
        checks++; if (o_locked !== 1'b1 || o_frame_lines !== 10'd12) begin errors++; $display("FAIL voff_lock: got locked=%b lines=%0d want 1/12", o_locked, o_frame_lines); end
    endtask

    task automatic test_reset_mid;
        int e0;
        e0 = err_cnt;
        send_frame(0, -1, 5 * HT + 15);
        checks++; if (o_pix_valid !== 1'b1 || o_locked !== 1'b1) begin errors++; $display("FAIL mid_pre: got valid=%b locked=%b want 1/1", o_pix_valid, o_locked); end
        i_rst = 1'b1;
        cyc(1'b1, 1'b1, 10'd6, 10'd2, 10'h155);
        checks++; if (o_pix_valid !== 1'b0 || o_locked !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL mid_flags: got valid=%b locked=%b err=%b want 0", o_pix_valid, o_locked, o_err); end
        checks++; if ({o_x, o_y, o_red, o_green, o_blue} !== 50'd0) begin errors++; $display("FAIL mid_data: got %h want 0", {o_x, o_y, o_red, o_green, o_blue}); end
        checks++; if ({o_line_len, o_hsync_width, o_frame_lines} !== 30'd0) begin errors++; $display("FAIL mid_meas: got %h want 0", {o_line_len, o_hsync_width, o_frame_lines}); end
        i_rst = 1'b0;
        send_frame(0, -1, -1);
        send_frame(0, -1, -1);
        checks++; if (o_locked !== 1'b0) begin errors++; $display("FAIL mid_relock_early: got %b want 0", o_locked); end
        send_frame(0, -1, -1);
        checks++; if (o_locked !== 1'b1 || err_cnt - e0 !== 0) begin errors++; $display("FAIL mid_relock: got locked=%b err=%0d want 1/0", o_locked, err_cnt - e0); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_back_to_back();
        test_short_line();
        test_timeout();
        test_vsync_offset();
        test_reset_mid();
        checks++; if (mon_bad !== 0) begin errors++; $display("FAIL gating_total: got %0d bad beats want 0", mon_bad); end
        checks++; if (err_cnt !== 2) begin errors++; $display("FAIL err_total: got %0d pulses want 2", err_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
